register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags for the out-of-order core. It holds 32 × 32-bit integer registers plus, per register, the ROB tag of the youngest in-flight producer. The decoder reads operand values or pending tags from it and renames destinations into it. The ROB's commit stage writes retired results into it, and a misbranch flushes all pending tags.

## Interface
Parameters (from shared constants):
- DATA_WIDTH, 32, register value width
- REG_WIDTH, 5, register index width
- ROB_WIDTH, 4, ROB tag width; tag 0 (ZERO_ROB) means "no pending producer"

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global enable; low freezes all state
- in_flush  in  1  misbranch from ROB; clears all tags
- in_commit_reg  in  REG_WIDTH  committed destination register (0 = no write)
- in_commit_rob  in  ROB_WIDTH  ROB tag of the committing entry
- in_commit_value  in  DATA_WIDTH  committed result
- in_rename_ena  in  1  decoder issues an instruction with a destination
- in_rename_reg  in  REG_WIDTH  destination being renamed
- in_rename_rob  in  ROB_WIDTH  ROB tag allocated to it
- in_query_reg1, in_query_reg2  in  REG_WIDTH  source operand indices
- out_value1, out_value2  out  DATA_WIDTH  register value (valid when tag is 0)
- out_tag1, out_tag2  out  ROB_WIDTH  pending producer tag, 0 if value is final

## Operation
- State: value_arr[0..31], tag_arr[0..31]. x0 is hardwired: value 0, tag 0, never written.
- Commit (edge, ena=1, in_commit_reg≠0):
  - value_arr[reg] ← in_commit_value, unconditionally.
  - tag_arr[reg] ← 0 only if tag_arr[reg]==in_commit_rob. Otherwise a younger producer still owns the register and the tag is kept.
- Rename (edge, ena=1, in_rename_ena=1, in_rename_reg≠0): tag_arr[reg] ← in_rename_rob.
- Commit and rename on the same register in the same cycle: the value is written and the tag becomes in_rename_rob. The rename wins the tag.
- Flush (edge, ena=1, in_flush=1):
  - All tags ← 0.
  - The same-cycle commit value is still written, because a JALR commit accompanies its own misbranch.
  - A same-cycle rename is dropped.
- Query, per port, combinational:
  - reg=0: value 0, tag 0.
  - Else if in_commit_reg==reg and tag_arr[reg]==in_commit_rob: value=in_commit_value, tag=0 (commit bypass).
  - Else: value=value_arr[reg], tag=tag_arr[reg].
  - A same-cycle rename never affects query outputs, so rs==rd sees the older producer.
- ena=0: no state update. Queries remain live.

## Timing
- Reset (rst=1 at edge): all values 0 and all tags 0, overriding ena, commit, rename and flush. After reset every query returns value 0, tag 0.
- Query path is zero-latency combinational from state and the commit inputs.
- Rename becomes visible to queries on the cycle after its edge.
- Commit becomes visible in the same cycle through the bypass, then from state on the next cycle.
- No handshakes: commit inputs are a registered, one-cycle pulse from the ROB, and rename is qualified by in_rename_ena.
- Priority at an edge: rst > flush (tags) > rename (tag) > commit tag clear. The value write is independent of flush and rename.

## Structure
- Constants DATA_WIDTH, REG_WIDTH, ROB_WIDTH, ZERO_ROB, ZERO_DATA live in the shared constant.v include.
- No typedefs.
- One natural sub-module: regfile_read_port, containing the x0 check and commit bypass. It is instantiated twice.
- Estimated 120–180 lines of RTL.

## Test plan
- Reset, then query x5 and x0 → value 0, tag 0 on both ports.
- Rename x5→tag 3. Next cycle query x5 → tag 3. Commit x5, tag 3, value 0x1234 → same-cycle query gives 0x1234 with tag 0. Next cycle, stored state gives the same.
- Rename x7→tag 2, then x7→tag 4. Commit x7, tag 2, value 0xAA → value_arr[x7]=0xAA, query tag stays 4.
- Same edge: commit x9 tag 1 value 0x55 and rename x9→tag 6 → next cycle value 0x55, tag 6.
- Tags pending on x1, x2, x3. Assert flush together with commit x1 tag t1 value 0x77 and rename x4→5 → next cycle all tags 0, x1=0x77, x4 tag 0.
- Commit and rename targeting x0, and separately any activity with ena=0 → no state change; x0 always reads value 0, tag 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared widths and zero constants for the architectural register file
// and its read ports.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_WIDTH  = 5;
    localparam int ROB_WIDTH  = 4;
    localparam int REG_COUNT  = 1 << REG_WIDTH;

    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational operand read port: forces x0 to zero and forwards a
// same-cycle commit whose ROB tag still owns the queried register.
module regfile_read_port
    import register_file_pkg::*;
(
    input  logic [REG_WIDTH-1:0]  query_reg,
    input  logic [REG_WIDTH-1:0]  commit_reg,
    input  logic [ROB_WIDTH-1:0]  commit_rob,
    input  logic [DATA_WIDTH-1:0] commit_value,
    input  logic [DATA_WIDTH-1:0] stored_value,
    input  logic [ROB_WIDTH-1:0]  stored_tag,
    output logic [DATA_WIDTH-1:0] value,
    output logic [ROB_WIDTH-1:0]  tag
);

    // A commit only bypasses when it is the youngest producer; an older
    // commit must not hide a newer pending tag.
    always_comb begin
        value = stored_value;
        tag   = stored_tag;
        if (query_reg == ZERO_REG) begin
            value = ZERO_DATA;
            tag   = ZERO_ROB;
        end else if (commit_reg == query_reg && stored_tag == commit_rob) begin
            value = commit_value;
            tag   = ZERO_ROB;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags: commit writes
// retired values, rename records the youngest producer, flush drops all tags.
module register_file
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_flush,
    input  logic [REG_WIDTH-1:0]  in_commit_reg,
    input  logic [ROB_WIDTH-1:0]  in_commit_rob,
    input  logic [DATA_WIDTH-1:0] in_commit_value,
    input  logic                  in_rename_ena,
    input  logic [REG_WIDTH-1:0]  in_rename_reg,
    input  logic [ROB_WIDTH-1:0]  in_rename_rob,
    input  logic [REG_WIDTH-1:0]  in_query_reg1,
    input  logic [REG_WIDTH-1:0]  in_query_reg2,
    output logic [DATA_WIDTH-1:0] out_value1,
    output logic [DATA_WIDTH-1:0] out_value2,
    output logic [ROB_WIDTH-1:0]  out_tag1,
    output logic [ROB_WIDTH-1:0]  out_tag2
);

    logic [DATA_WIDTH-1:0] value_arr [REG_COUNT];
    logic [ROB_WIDTH-1:0]  tag_arr   [REG_COUNT];

    // Later assignments win the tag: commit clear, then rename, then flush.
    // The committed value is written regardless of rename or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_arr[i] <= ZERO_DATA;
                tag_arr[i]   <= ZERO_ROB;
            end
        end else if (ena) begin
            if (in_commit_reg != ZERO_REG) begin
                value_arr[in_commit_reg] <= in_commit_value;
                if (tag_arr[in_commit_reg] == in_commit_rob)
                    tag_arr[in_commit_reg] <= ZERO_ROB;
            end
            if (in_rename_ena && in_rename_reg != ZERO_REG)
                tag_arr[in_rename_reg] <= in_rename_rob;
            if (in_flush) begin
                for (int i = 0; i < REG_COUNT; i++)
                    tag_arr[i] <= ZERO_ROB;
            end
        end
    end

    regfile_read_port port1 (
        .query_reg    (in_query_reg1),
        .commit_reg   (in_commit_reg),
        .commit_rob   (in_commit_rob),
        .commit_value (in_commit_value),
        .stored_value (value_arr[in_query_reg1]),
        .stored_tag   (tag_arr[in_query_reg1]),
        .value        (out_value1),
        .tag          (out_tag1)
    );

    regfile_read_port port2 (
        .query_reg    (in_query_reg2),
        .commit_reg   (in_commit_reg),
        .commit_rob   (in_commit_rob),
        .commit_value (in_commit_value),
        .stored_value (value_arr[in_query_reg2]),
        .stored_tag   (tag_arr[in_query_reg2]),
        .value        (out_value2),
        .tag          (out_tag2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed table-driven bench for register_file: each row drives one cycle
// of inputs, checks the pre-edge query outputs, then clocks the edge.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        in_flush;
    logic [4:0]  in_commit_reg;
    logic [3:0]  in_commit_rob;
    logic [31:0] in_commit_value;
    logic        in_rename_ena;
    logic [4:0]  in_rename_reg;
    logic [3:0]  in_rename_rob;
    logic [4:0]  in_query_reg1;
    logic [4:0]  in_query_reg2;
    logic [31:0] out_value1;
    logic [31:0] out_value2;
    logic [3:0]  out_tag1;
    logic [3:0]  out_tag2;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        ena;
        logic        flush;
        logic [4:0]  creg;
        logic [3:0]  crob;
        logic [31:0] cval;
        logic        rena;
        logic [4:0]  rreg;
        logic [3:0]  rrob;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [31:0] ev1;
        logic [3:0]  et1;
        logic [31:0] ev2;
        logic [3:0]  et2;
    } vec_t;

    vec_t vecs[$];

    register_file dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .in_flush        (in_flush),
        .in_commit_reg   (in_commit_reg),
        .in_commit_rob   (in_commit_rob),
        .in_commit_value (in_commit_value),
        .in_rename_ena   (in_rename_ena),
        .in_rename_reg   (in_rename_reg),
        .in_rename_rob   (in_rename_rob),
        .in_query_reg1   (in_query_reg1),
        .in_query_reg2   (in_query_reg2),
        .out_value1      (out_value1),
        .out_value2      (out_value2),
        .out_tag1        (out_tag1),
        .out_tag2        (out_tag2)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic e, logic f, logic [4:0] cr, logic [3:0] cb,
                                logic [31:0] cv, logic re, logic [4:0] rr,
                                logic [3:0] rb, logic [4:0] a, logic [4:0] b,
                                logic [31:0] v1, logic [3:0] t1,
                                logic [31:0] v2, logic [3:0] t2);
        vec_t v;
        v.ena = e;  v.flush = f; v.creg = cr; v.crob = cb; v.cval = cv;
        v.rena = re; v.rreg = rr; v.rrob = rb; v.q1 = a; v.q2 = b;
        v.ev1 = v1; v.et1 = t1; v.ev2 = v2; v.et2 = t2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic drive(input vec_t v);
        ena             = v.ena;
        in_flush        = v.flush;
        in_commit_reg   = v.creg;
        in_commit_rob   = v.crob;
        in_commit_value = v.cval;
        in_rename_ena   = v.rena;
        in_rename_reg   = v.rreg;
        in_rename_rob   = v.rrob;
        in_query_reg1   = v.q1;
        in_query_reg2   = v.q2;
    endtask

    task automatic apply_vector(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check($sformatf("vec%0d value1", idx), out_value1, v.ev1);
        check($sformatf("vec%0d tag1", idx), {28'd0, out_tag1}, {28'd0, v.et1});
        check($sformatf("vec%0d value2", idx), out_value2, v.ev2);
        check($sformatf("vec%0d tag2", idx), {28'd0, out_tag2}, {28'd0, v.et2});
    endtask

    initial begin
        //            ena fl creg crob cval         re rreg rrob q1 q2  ev1          et1 ev2          et2
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  5, 0,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 5, 3,  5, 5,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  5, 0,  32'h0,        3, 32'h0,        0));
        vecs.push_back(mk(1, 0, 5, 3, 32'h1234,     0, 0, 0,  5, 5,  32'h1234,     0, 32'h1234,     0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  5, 0,  32'h1234,     0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 7, 2,  7, 7,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 7, 4,  7, 5,  32'h0,        2, 32'h1234,     0));
        vecs.push_back(mk(1, 0, 7, 2, 32'hAA,       0, 0, 0,  7, 5,  32'h0,        4, 32'h1234,     0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  7, 0,  32'hAA,       4, 32'h0,        0));
        vecs.push_back(mk(1, 0, 9, 1, 32'h55,       1, 9, 6,  9, 9,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  9, 7,  32'h55,       6, 32'hAA,       4));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 1, 1,  1, 0,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 2, 2,  1, 0,  32'h0,        1, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 3, 3,  2, 0,  32'h0,        2, 32'h0,        0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h77,       1, 4, 5,  1, 3,  32'h77,       0, 32'h0,        3));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  1, 2,  32'h77,       0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  3, 4,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  9, 7,  32'h55,       0, 32'hAA,       0));
        vecs.push_back(mk(1, 0, 0, 0, 32'hDEAD,     1, 0, 7,  0, 0,  32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  0, 5,  32'h0,        0, 32'h1234,     0));
        vecs.push_back(mk(0, 1, 5, 0, 32'hBEEF,     1, 6, 2,  5, 1,  32'hBEEF,     0, 32'h77,       0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0,  5, 6,  32'h1234,     0, 32'h0,        0));

        drive(mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            apply_vector(i, vecs[i]);

        // Reset must override a same-edge rename, commit and flush.
        @(negedge clk);
        drive(mk(1, 1, 7, 0, 32'h1, 1, 5, 3, 5, 7, 32'h0, 0, 32'h0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 5, 7, 32'h0, 0, 32'h0, 0));
        #1;
        check("reset value x5", out_value1, 32'h0);
        check("reset tag x5", {28'd0, out_tag1}, 32'h0);
        check("reset value x7", out_value2, 32'h0);
        check("reset tag x7", {28'd0, out_tag2}, 32'h0);
        in_query_reg1 = 5'd1;
        in_query_reg2 = 5'd9;
        #1;
        check("reset value x1", out_value1, 32'h0);
        check("reset value x9", out_value2, 32'h0);

        // An older commit to a register renamed in the same cycle must not
        // clear the newer tag, and the value still lands.
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 32'h0, 1, 12, 8, 12, 0, 32'h0, 0, 32'h0, 0));
        @(negedge clk);
        drive(mk(1, 0, 12, 8, 32'hCAFE, 1, 12, 9, 12, 0, 32'h0, 0, 32'h0, 0));
        #1;
        check("commit+rename bypass value", out_value1, 32'hCAFE);
        check("commit+rename bypass tag", {28'd0, out_tag1}, 32'h0);
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 12, 0, 32'h0, 0, 32'h0, 0));
        #1;
        check("rename wins value", out_value1, 32'hCAFE);
        check("rename wins tag", {28'd0, out_tag1}, 32'h9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
